// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the RV32I unified-memory port arbiter.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    function automatic owner_e state_owner(input arb_state_e s);
        return (s == D_BUSY) ? OWN_D : OWN_IF;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Access timeout counter: counts busy cycles and flags expiry on the last allowed cycle.
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and load/store,
// data first with a bounded streak so fetch cannot starve.
module mem_port_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_e          state, state_next;
    owner_e              owner;
    logic [STREAK_W-1:0] streak;
    logic                busy, if_elig, d_elig, grant_d, grant_if, done, abort, wd_expire;

    assign if_stall = if_req && !if_valid;
    assign d_stall  = d_req && !d_valid;

    // A requester whose valid is high this cycle is still showing its finished request.
    assign if_elig = if_req && !if_valid;
    assign d_elig  = d_req && !d_valid;

    assign busy  = (state != IDLE);
    assign owner = state_owner(state);
    assign done  = busy && mem_ready;
    assign abort = wd_expire && !mem_ready;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!busy || mem_ready || wd_expire),
        .enable (busy),
        .expire (wd_expire)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can infer a latch.
        state_next = state;
        grant_d    = 1'b0;
        grant_if   = 1'b0;
        case (state)
            IDLE: begin
                grant_d  = d_elig && !((streak == STREAK_MAX) && if_elig);
                grant_if = if_elig && !grant_d;
                if (grant_d) begin
                    state_next = D_BUSY;
                end else if (grant_if) begin
                    state_next = IF_BUSY;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (done || abort) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: all state updates are non-blocking so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            err        <= 1'b0;
            streak     <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
            if (grant_d) begin
                mem_req    <= 1'b1;
                mem_we     <= d_we;
                mem_addr   <= d_addr;
                mem_wdata  <= d_wdata;
                mem_funct3 <= d_funct3;
                if (!if_req)                 streak <= '0;
                else if (streak != STREAK_MAX) streak <= streak + STREAK_W'(1);
            end else if (grant_if) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
                mem_funct3 <= FUNCT3_WORD;
                streak     <= '0;
            end else if (done) begin
                mem_req <= 1'b0;
                if (owner == OWN_D) begin
                    d_valid <= 1'b1;
                    if (!mem_we) d_rdata <= mem_rdata;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_rdata;
                end
            end else if (abort) begin
                mem_req <= 1'b0;
                err     <= 1'b1;
                if (owner == OWN_D) begin
                    d_valid <= 1'b1;
                    d_rdata <= '0;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle vector table plus starvation and timeout sequences.
module tb_mem_port_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] IA  = 32'h0000_0010;
    localparam logic [31:0] DA  = 32'h0000_0020;
    localparam logic [31:0] WD  = 32'hDEAD_BEEF;
    localparam logic [31:0] G   = 32'hBAD0_0BAD;
    localparam logic [2:0]  F3D = 3'b001;
    localparam logic [2:0]  FW  = 3'b010;
    localparam logic [2:0]  F0  = 3'b000;
    localparam int NV = 24;

    logic        clk, rst;
    logic        if_req, if_valid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_valid, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_funct3, mem_funct3;
    logic        mem_req, mem_we, mem_ready, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, if_req, d_req, d_we, ready;
        logic [31:0] rdata;
        logic        e_req, e_we;
        logic [31:0] e_addr;
        logic [2:0]  e_f3;
        logic        e_iv, e_dv, e_err, e_ist, e_dst;
        logic [31:0] e_ird, e_drd;
        logic        chk_w;
    } vec_t;

    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: bench did not finish in time");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int   n_dg, err_at;
        logic got_if, dropped;

        //            rst if d  we rdy rdata          | req we addr f3  iv dv er ist dst ird           drd           w
        vecs[0]  = '{L, L, L, L, L, G,              L, L, 32'h0, F0, L, L, L, L, L, 32'h0,         32'h0,        L};
        // fetch only, memory answers one cycle after mem_req
        vecs[1]  = '{H, H, L, L, L, G,              H, L, IA, FW, L, L, L, H, L, 32'h0,         32'h0,        L};
        vecs[2]  = '{H, H, L, L, L, G,              H, L, IA, FW, L, L, L, H, L, 32'h0,         32'h0,        L};
        vecs[3]  = '{H, H, L, L, H, 32'h00A00093,   L, L, IA, FW, H, L, L, L, L, 32'h00A00093,  32'h0,        L};
        vecs[4]  = '{H, L, L, L, L, G,              L, L, IA, FW, L, L, L, L, L, 32'h00A00093,  32'h0,        L};
        // simultaneous requests: store wins, fetch follows
        vecs[5]  = '{H, H, H, H, L, G,              H, H, DA, F3D, L, L, L, H, H, 32'h00A00093, 32'h0,        H};
        vecs[6]  = '{H, H, H, H, H, G,              L, H, DA, F3D, L, H, L, H, L, 32'h00A00093, 32'h0,        H};
        vecs[7]  = '{H, H, L, L, L, G,              H, L, IA, FW, L, L, L, H, L, 32'h00A00093,  32'h0,        L};
        vecs[8]  = '{H, H, L, L, H, 32'h00000513,   L, L, IA, FW, H, L, L, L, L, 32'h00000513,  32'h0,        L};
        vecs[9]  = '{H, L, L, L, L, G,              L, L, IA, FW, L, L, L, L, L, 32'h00000513,  32'h0,        L};
        // zero-wait memory, alternating owners, stale requests masked
        vecs[10] = '{H, L, H, L, H, G,              H, L, DA, F3D, L, L, L, L, H, 32'h00000513, 32'h0,        L};
        vecs[11] = '{H, L, H, L, H, 32'h11111111,   L, L, DA, F3D, L, H, L, L, L, 32'h00000513, 32'h11111111, L};
        vecs[12] = '{H, H, H, L, H, G,              H, L, IA, FW, L, L, L, H, H, 32'h00000513,  32'h11111111, L};
        vecs[13] = '{H, H, H, L, H, 32'h22222222,   L, L, IA, FW, H, L, L, L, H, 32'h22222222,  32'h11111111, L};
        vecs[14] = '{H, H, H, L, H, G,              H, L, DA, F3D, L, L, L, H, H, 32'h22222222, 32'h11111111, L};
        vecs[15] = '{H, L, H, L, H, 32'h33333333,   L, L, DA, F3D, L, H, L, L, L, 32'h22222222, 32'h33333333, L};
        vecs[16] = '{H, L, H, L, H, G,              L, L, DA, F3D, L, L, L, L, H, 32'h22222222, 32'h33333333, L};
        vecs[17] = '{H, L, L, L, H, G,              L, L, DA, F3D, L, L, L, L, L, 32'h22222222, 32'h33333333, L};
        // reset during a data access, late ready during reset, then a clean fetch
        vecs[18] = '{H, L, H, L, L, G,              H, L, DA, F3D, L, L, L, L, H, 32'h22222222, 32'h33333333, L};
        vecs[19] = '{L, L, L, L, L, G,              L, L, 32'h0, F0, L, L, L, L, L, 32'h0,         32'h0,        L};
        vecs[20] = '{L, L, L, L, H, G,              L, L, 32'h0, F0, L, L, L, L, L, 32'h0,         32'h0,        L};
        vecs[21] = '{H, H, L, L, L, G,              H, L, IA, FW, L, L, L, H, L, 32'h0,         32'h0,        L};
        vecs[22] = '{H, H, L, L, H, 32'h00100073,   L, L, IA, FW, H, L, L, L, L, 32'h00100073,  32'h0,        L};
        vecs[23] = '{H, L, L, L, L, G,              L, L, IA, FW, L, L, L, L, L, 32'h00100073,  32'h0,        L};

        if_addr  = IA;
        d_addr   = DA;
        d_wdata  = WD;
        d_funct3 = F3D;

        for (int i = 0; i < NV; i++) begin
            rst       = vecs[i].rst;
            if_req    = vecs[i].if_req;
            d_req     = vecs[i].d_req;
            d_we      = vecs[i].d_we;
            mem_ready = vecs[i].ready;
            mem_rdata = vecs[i].rdata;
            step();
            check($sformatf("v%0d mem_req", i),    32'(mem_req),    32'(vecs[i].e_req));
            check($sformatf("v%0d mem_we", i),     32'(mem_we),     32'(vecs[i].e_we));
            check($sformatf("v%0d mem_addr", i),   mem_addr,        vecs[i].e_addr);
            check($sformatf("v%0d mem_funct3", i), 32'(mem_funct3), 32'(vecs[i].e_f3));
            check($sformatf("v%0d if_valid", i),   32'(if_valid),   32'(vecs[i].e_iv));
            check($sformatf("v%0d d_valid", i),    32'(d_valid),    32'(vecs[i].e_dv));
            check($sformatf("v%0d err", i),        32'(err),        32'(vecs[i].e_err));
            check($sformatf("v%0d if_stall", i),   32'(if_stall),   32'(vecs[i].e_ist));
            check($sformatf("v%0d d_stall", i),    32'(d_stall),    32'(vecs[i].e_dst));
            check($sformatf("v%0d if_rdata", i),   if_rdata,        vecs[i].e_ird);
            check($sformatf("v%0d d_rdata", i),    d_rdata,         vecs[i].e_drd);
            if (vecs[i].chk_w) check($sformatf("v%0d mem_wdata", i), mem_wdata, WD);
        end

        // Starvation: back-to-back loads against a pending fetch that steps aside
        // only in the cycle where a load completes.
        d_req     = 1'b1;
        d_we      = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        n_dg      = 0;
        got_if    = 1'b0;
        for (int c = 0; c < 60 && !got_if; c++) begin
            if_req = !d_valid;
            step();
            if (mem_req && mem_addr == DA)      n_dg++;
            else if (mem_req && mem_addr == IA) got_if = 1'b1;
        end
        check("starve fetch_granted", 32'(got_if), 32'd1);
        check("starve data_grants_before_fetch", 32'(n_dg), 32'd4);
        check("starve if_stall_while_busy", 32'(if_stall), 32'd1);
        d_req     = 1'b0;
        mem_rdata = 32'h0000_0013;
        step();
        check("starve if_valid", 32'(if_valid), 32'd1);
        check("starve if_rdata", if_rdata, 32'h0000_0013);
        check("starve d_rdata", d_rdata, 32'h5A5A_5A5A);
        if_req = 1'b0;
        step();

        // Timeout: memory never answers a load.
        d_req     = 1'b1;
        d_we      = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = G;
        step();
        check("timeout grant mem_req", 32'(mem_req), 32'd1);
        check("timeout mem_funct3", 32'(mem_funct3), 32'(F3D));
        err_at  = -1;
        dropped = 1'b0;
        for (int k = 1; k <= 100 && err_at < 0; k++) begin
            step();
            if (err)           err_at = k;
            else if (!mem_req) dropped = 1'b1;
        end
        check("timeout err_cycle", 32'(err_at), 32'd64);
        check("timeout mem_req_held", 32'(dropped), 32'd0);
        check("timeout d_valid", 32'(d_valid), 32'd1);
        check("timeout d_rdata", d_rdata, 32'h0);
        check("timeout mem_req_dropped", 32'(mem_req), 32'd0);
        d_req     = 1'b0;
        mem_ready = 1'b1;
        step();
        check("late_ready err", 32'(err), 32'd0);
        check("late_ready d_valid", 32'(d_valid), 32'd0);
        check("late_ready mem_req", 32'(mem_req), 32'd0);
        check("late_ready d_rdata", d_rdata, 32'h0);
        if_req    = 1'b1;
        mem_ready = 1'b0;
        step();
        check("post_timeout fetch mem_req", 32'(mem_req), 32'd1);
        check("post_timeout fetch mem_addr", mem_addr, IA);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0297;
        step();
        check("post_timeout if_valid", 32'(if_valid), 32'd1);
        check("post_timeout if_rdata", if_rdata, 32'h0000_0297);
        check("post_timeout err", 32'(err), 32'd0);
        if_req    = 1'b0;
        mem_ready = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the RV32I pipeline.
- Sequences each access through a request/ready handshake with variable memory latency.
- Gives data accesses priority, with an anti-starvation limit, and reports per-requester stall to the hazard detection unit.
- Includes a watchdog that aborts hung accesses.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending
- TIMEOUT, 64, cycles to wait for mem_ready before aborting an access

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req && !if_valid
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_funct3  in  3  access size/sign, passed to memory
- d_rdata  out  DATA_W  load data
- d_valid  out  1  one-cycle data completion pulse
- d_stall  out  1  d_req && !d_valid
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_funct3  out  3  memory size; 3'b010 for fetches
- mem_ready  in  1  memory completion (may arrive in the first mem_req cycle)
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; all outputs 0; streak and watchdog counters 0.
  - Reset mid-access abandons the access with no valid pulse.
- FSM states: IDLE, IF_BUSY, D_BUSY.
- IDLE:
  - Eligible requester = req high and its own valid not asserted this cycle. This masks the stale req in the cycle after completion.
  - Grant rule: data is granted if eligible, unless streak==MAX_D_STREAK and fetch is eligible, in which case fetch wins.
  - On grant, register mem_addr/mem_we/mem_wdata/mem_funct3 from the winner and set mem_req=1 at the next edge; move to the matching BUSY state.
  - Fetch grants force mem_we=0 and mem_funct3=3'b010.
- BUSY:
  - mem_req and the mem_* fields are held stable; watchdog increments each cycle.
  - On mem_ready: mem_req=0, return to IDLE, and the owner's valid=1 for exactly one cycle.
  - rdata is latched from mem_rdata and held until that owner's next completion. Stores return rdata unchanged.
- Minimum latency: request seen in IDLE at cycle 0, mem_req at 1, mem_ready at 1 gives valid at 2.
- Streak counter:
  - Increments on each data grant while if_req is high, saturating at MAX_D_STREAK.
  - Clears on any fetch grant or when if_req is low at a data grant.
- Watchdog:
  - If the counter reaches TIMEOUT-1 without mem_ready: drop mem_req, pulse err and the owner's valid together with rdata=0, return to IDLE, clear the counter.
  - mem_ready arriving after an abort is ignored.
- Simultaneous request: both req rise in the same IDLE cycle gives data first, fetch next.
- Requester rules:
  - Request signals must remain stable from req assertion until valid.
  - Dropping req mid-access does not cancel the access; the valid pulse still issues.
- Stalls are combinational. Everything else is registered.

Decomposition:
- Shared package rv32_mem_pkg holds:
  - the state encoding (IDLE=2'd0, IF_BUSY=2'd1, D_BUSY=2'd2);
  - FUNCT3_WORD=3'b010;
  - the owner enum (OWN_IF, OWN_D).
- One sub-module, arb_watchdog: the timeout counter with clear/enable/expire.
- Grant logic and the FSM stay in the top module.

Test Plan:
- Fetch-only: if_req=1, if_addr=0x00000010, mem_ready one cycle after mem_req with rdata=0x00A00093 -> if_valid pulses at cycle 3; if_rdata=0x00A00093; mem_funct3=010; mem_we=0.
- Conflict: if_req and d_req rise together, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> first mem access is the write to 0x20; fetch issues after d_valid; if_stall high throughout.
- Starvation: d_req held high for 10 back-to-back loads, if_req high -> a fetch is granted after exactly 4 data grants.
- Timeout: mem_ready stuck 0 with TIMEOUT=64 -> err and d_valid pulse at 64 cycles after mem_req; d_rdata=0; FSM back in IDLE; a late mem_ready is ignored.
- Reset mid-access: rst=0 during D_BUSY -> next cycle all outputs 0, no d_valid; after release, a new fetch completes normally.
- Zero-wait memory: mem_ready tied high, alternating requests -> each access takes 2 cycles; no duplicate grant from a stale req.
